// File: rtl/hex_cal_pkg.sv
// Shared definitions for the hex calculator output formatter: FSM state
// encoding, ASCII constants and a small nibble helper.
package hex_cal_pkg;

  // Frame sequencer states. StCr/StLf are only reachable when HEX_FMT_CRLF_EN is defined.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StEq   = 3'd1,
    StHi   = 3'd2,
    StLo   = 3'd3,
    StCr   = 3'd4,
    StLf   = 3'd5
  } fmt_state_e;

  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_ONE   = 8'h31;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Magnitude of a negative 4-bit two's-complement result; 0 stays 0 ("-0").
  function automatic logic [3:0] neg_nibble(input logic [3:0] value);
    return (~value) + 4'd1;
  endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit to uppercase hex ASCII converter.
module nibble_to_ascii
  import hex_cal_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  // 0-9 map onto '0'..'9', 10-15 onto 'A'..'F'.
  always_comb begin
    o_ascii = ASCII_ZERO;
    if (i_nibble < 4'd10) begin
      o_ascii = ASCII_ZERO + {4'h0, i_nibble};
    end else begin
      o_ascii = ASCII_A + {4'h0, i_nibble - 4'd10};
    end
  end

endmodule

// File: rtl/hex_result_fmt.sv
// Formats one 4-bit add/sub result as an ASCII frame "=D1D0" for the UART TX.
// Build option: define HEX_FMT_CRLF_EN to append CR LF to every frame.
module hex_result_fmt
  import hex_cal_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       res_valid,
  output logic       res_ready,
  input  logic       op_sub,
  input  logic [3:0] sum,
  input  logic       c_out,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  fmt_state_e r_state, w_state_next;
  logic       r_op_sub, r_c_out;
  logic [3:0] r_sum;
  logic [7:0] r_tx_data, w_tx_data_next;
  logic       r_tx_valid, w_tx_valid_next;

  logic       w_accept;
  logic       w_negative;
  logic [3:0] w_lo_nibble;
  logic [7:0] w_lo_ascii;
  logic [7:0] w_hi_byte;

  assign w_accept   = res_valid && (r_state == StIdle);
  assign w_negative = r_op_sub && !r_c_out;

  // D0 shows the magnitude, so negative subtraction results are re-negated.
  assign w_lo_nibble = w_negative ? neg_nibble(r_sum) : r_sum;

  nibble_to_ascii u_lo_digit (
    .i_nibble (w_lo_nibble),
    .o_ascii  (w_lo_ascii)
  );

  // D1: carry digit for add, sign for subtract.
  always_comb begin
    w_hi_byte = ASCII_ZERO;
    if (!r_op_sub) begin
      w_hi_byte = r_c_out ? ASCII_ONE : ASCII_ZERO;
    end else begin
      w_hi_byte = r_c_out ? ASCII_ZERO : ASCII_MINUS;
    end
  end

  // Latch the result operands on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_sub <= 1'b0;
      r_sum    <= 4'h0;
      r_c_out  <= 1'b0;
    end else if (w_accept) begin
      r_op_sub <= op_sub;
      r_sum    <= sum;
      r_c_out  <= c_out;
    end
  end

  // State and registered TX outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tx_data  <= w_tx_data_next;
      r_tx_valid <= w_tx_valid_next;
    end
  end

  // Next state plus the byte to present after the transition; holds on stall.
  always_comb begin
    w_state_next    = r_state;
    w_tx_data_next  = r_tx_data;
    w_tx_valid_next = r_tx_valid;
    case (r_state)
      StIdle: begin
        if (res_valid) begin
          w_state_next    = StEq;
          w_tx_data_next  = ASCII_EQ;
          w_tx_valid_next = 1'b1;
        end
      end
      StEq: begin
        if (tx_ready) begin
          w_state_next   = StHi;
          w_tx_data_next = w_hi_byte;
        end
      end
      StHi: begin
        if (tx_ready) begin
          w_state_next   = StLo;
          w_tx_data_next = w_lo_ascii;
        end
      end
      StLo: begin
        if (tx_ready) begin
`ifdef HEX_FMT_CRLF_EN
          w_state_next   = StCr;
          w_tx_data_next = ASCII_CR;
`else
          w_state_next    = StIdle;
          w_tx_data_next  = 8'h00;
          w_tx_valid_next = 1'b0;
`endif
        end
      end
`ifdef HEX_FMT_CRLF_EN
      StCr: begin
        if (tx_ready) begin
          w_state_next   = StLf;
          w_tx_data_next = ASCII_LF;
        end
      end
      StLf: begin
        if (tx_ready) begin
          w_state_next    = StIdle;
          w_tx_data_next  = 8'h00;
          w_tx_valid_next = 1'b0;
        end
      end
`endif
      default: begin
        w_state_next    = StIdle;
        w_tx_data_next  = 8'h00;
        w_tx_valid_next = 1'b0;
      end
    endcase
  end

  assign res_ready = (r_state == StIdle);
  assign busy      = (r_state != StIdle);
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;

endmodule

// File: tb/tb_hex_result_fmt.sv
// Self-checking bench for hex_result_fmt; follows HEX_FMT_CRLF_EN for frame length.
module tb_hex_result_fmt;

  typedef logic [7:0] byte_q_t[$];

`ifdef HEX_FMT_CRLF_EN
  localparam int FrameLen = 5;
`else
  localparam int FrameLen = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       res_valid = 1'b0;
  logic       res_ready;
  logic       op_sub = 1'b0;
  logic [3:0] sum = 4'h0;
  logic       c_out = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  hex_result_fmt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .op_sub    (op_sub),
    .sum       (sum),
    .c_out     (c_out),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] hexc(input int d);
    return (d < 10) ? 8'(48 + d) : 8'(55 + d);
  endfunction

  // Reference: interpret the result arithmetically, then spell it out.
  function automatic byte_q_t model_frame(input bit op, input logic [3:0] s, input bit c);
    byte_q_t q;
    int v;
    q.push_back(8'h3D);
    if (!op) begin
      v = (c ? 16 : 0) + int'(s);
      q.push_back(v >= 16 ? 8'h31 : 8'h30);
      q.push_back(hexc(v % 16));
    end else if (c) begin
      q.push_back(8'h30);
      q.push_back(hexc(int'(s)));
    end else begin
      v = int'(s) - 16;
      q.push_back(8'h2D);
      q.push_back(hexc((-v) % 16));
    end
`ifdef HEX_FMT_CRLF_EN
    q.push_back(8'h0D);
    q.push_back(8'h0A);
`endif
    return q;
  endfunction

  function automatic string fmt(input byte_q_t q);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  function automatic bit same(input byte_q_t a, input byte_q_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Drives one result and collects handshaken bytes. Entered/exited #1 after a rising edge.
  task automatic run_frame(input bit op, input logic [3:0] s, input bit c, input int stall_pct,
                           output byte_q_t got, output int cycles, output int unstable,
                           output bit timeout);
    logic [7:0] prev;
    bit have_prev;
    int w;
    got = {};
    cycles = 0;
    unstable = 0;
    timeout = 1'b0;
    have_prev = 1'b0;
    prev = 8'h00;
    res_valid = 1'b1;
    op_sub = op;
    sum = s;
    c_out = c;
    tx_ready = 1'b0;
    w = 0;
    while (!res_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!res_ready) begin
      timeout = 1'b1;
      res_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (have_prev && (!tx_valid || tx_data !== prev)) unstable++;
      if (!tx_valid) break;
      cycles++;
      tx_ready = ($urandom_range(99) >= stall_pct);
      if (tx_ready) begin
        got.push_back(tx_data);
        have_prev = 1'b0;
      end else begin
        have_prev = 1'b1;
        prev = tx_data;
      end
      @(posedge clk); #1;
      if (k == 299) timeout = 1'b1;
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (tx_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++;
      $display("FAIL reset_tx_data: got %02h expected 00", tx_data); end
    n_vec++; if (res_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_res_ready: got %b expected 1", res_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL reset_busy: got %b expected 0", busy); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [5:0] vecs[6] = '{6'b0_1111_1, 6'b1_1110_0, 6'b1_0010_1,
                            6'b0_1010_0, 6'b0_0000_0, 6'b1_0000_0};
    byte_q_t got, exp;
    int cyc, uns;
    bit to;
    foreach (vecs[i]) begin
      run_frame(vecs[i][5], vecs[i][4:1], vecs[i][0], 0, got, cyc, uns, to);
      exp = model_frame(vecs[i][5], vecs[i][4:1], vecs[i][0]);
      n_vec++; if (to || !same(got, exp)) begin n_err++;
        $display("FAIL directed_frame[%0d]: got %s (timeout %0b) expected %s",
                 i, fmt(got), to, fmt(exp)); end
      n_vec++; if (cyc != FrameLen) begin n_err++;
        $display("FAIL directed_cycles[%0d]: got %0d expected %0d", i, cyc, FrameLen); end
      n_vec++; if (res_ready !== 1'b1 || tx_valid !== 1'b0) begin n_err++;
        $display("FAIL directed_idle[%0d]: got res_ready %b tx_valid %b expected 1 0",
                 i, res_ready, tx_valid); end
    end
  endtask

  task automatic test_backpressure();
    byte_q_t got, exp;
    got = {};
    exp = model_frame(1'b0, 4'hF, 1'b1);
    res_valid = 1'b1; op_sub = 1'b0; sum = 4'hF; c_out = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h3D) begin n_err++;
      $display("FAIL bp_first_byte: got %b/%02h expected 1/3d", tx_valid, tx_data); end
    got.push_back(tx_data);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h31 || res_ready !== 1'b0) begin n_err++;
        $display("FAIL bp_hold[%0d]: got valid %b data %02h res_ready %b expected 1 31 0",
                 i, tx_valid, tx_data, res_ready); end
      res_valid = (i == 1);
      op_sub = 1'b1; sum = 4'h3; c_out = 1'b0;
      @(posedge clk); #1;
    end
    res_valid = 1'b0;
    tx_ready = 1'b1;
    for (int k = 0; k < 20 && tx_valid; k++) begin
      got.push_back(tx_data);
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    n_vec++; if (!same(got, exp)) begin n_err++;
      $display("FAIL bp_frame: got %s expected %s", fmt(got), fmt(exp)); end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin n_err++;
      $display("FAIL bp_no_accept: got busy %b tx_valid %b expected 0 0", busy, tx_valid); end
  endtask

  task automatic test_reset_midframe();
    byte_q_t got, exp;
    int cyc, uns;
    bit to;
    res_valid = 1'b1; op_sub = 1'b0; sum = 4'hF; c_out = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++; if (tx_data !== 8'h46) begin n_err++;
      $display("FAIL mid_lo_byte: got %02h expected 46", tx_data); end
    tx_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (tx_valid !== 1'b0 || res_ready !== 1'b1 || busy !== 1'b0 || tx_data !== 8'h00)
      begin n_err++;
      $display("FAIL mid_async_reset: got valid %b ready %b busy %b data %02h expected 0 1 0 00",
               tx_valid, res_ready, busy, tx_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame(1'b0, 4'h0, 1'b0, 0, got, cyc, uns, to);
    exp = model_frame(1'b0, 4'h0, 1'b0);
    n_vec++; if (to || !same(got, exp)) begin n_err++;
      $display("FAIL mid_after_reset: got %s expected %s", fmt(got), fmt(exp)); end
  endtask

  task automatic test_random();
    byte_q_t got, exp;
    int cyc, uns;
    bit to, op, c;
    logic [3:0] s;
    for (int i = 0; i < 40; i++) begin
      op = 1'($urandom_range(1));
      c  = 1'($urandom_range(1));
      s  = 4'($urandom_range(15));
      run_frame(op, s, c, 35, got, cyc, uns, to);
      exp = model_frame(op, s, c);
      n_vec++; if (to || !same(got, exp)) begin n_err++;
        $display("FAIL rand_frame[%0d] op %0b sum %h c %0b: got %s expected %s",
                 i, op, s, c, fmt(got), fmt(exp)); end
      n_vec++; if (uns != 0) begin n_err++;
        $display("FAIL rand_stable[%0d]: got %0d unstable stalls expected 0", i, uns); end
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t got, exp;
    int cyc, uns;
    bit to, op, c;
    logic [3:0] s;
    for (int i = 0; i < 5; i++) begin
      op = 1'($urandom_range(1));
      c  = 1'($urandom_range(1));
      s  = 4'($urandom_range(15));
      run_frame(op, s, c, 0, got, cyc, uns, to);
      exp = model_frame(op, s, c);
      n_vec++; if (to || !same(got, exp) || cyc != FrameLen) begin n_err++;
        $display("FAIL b2b_frame[%0d]: got %s in %0d cycles expected %s in %0d",
                 i, fmt(got), cyc, fmt(exp), FrameLen); end
      n_vec++; if (res_ready !== 1'b1 || busy !== 1'b0) begin n_err++;
        $display("FAIL b2b_gap[%0d]: got res_ready %b busy %b expected 1 0",
                 i, res_ready, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midframe();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
